// File: rtl/uart_tx_buffered_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_buffered_pkg
// Purpose : Shared definitions for the buffered UART transmit path:
//           default line timing and the transmit FSM state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package uart_tx_buffered_pkg;

    localparam int c_DEFAULT_CLK_FREQ = 100_000_000;
    localparam int c_DEFAULT_BAUD     = 9600;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_buffered_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_buffered_if
// Purpose : System-side push handshake, status flags and serial line of the
//           buffered UART transmitter.
// Rev     : 1.0  initial release
// ============================================================================
interface uart_tx_buffered_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       sent;
    logic       overflow;
    logic       RsTx;

    modport master (
        output tx_start, tx_data,
        input  full, empty, busy, sent, overflow, RsTx
    );

    modport slave (
        input  tx_start, tx_data,
        output full, empty, busy, sent, overflow, RsTx
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_buffered_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_buffered_fifo
// Purpose : Synchronous byte FIFO with registered occupancy count. Pushes
//           while full and pops while empty are ignored; full is judged
//           before any same-cycle pop.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_buffered_fifo #(
    parameter int DEPTH = 16
) (
    input  wire        clk,
    input  wire        rst,
    input  wire        i_push,
    input  wire  [7:0] i_wr_data,
    input  wire        i_pop,
    output logic [7:0] o_rd_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int                 c_PTR_W      = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_COUNT = (c_PTR_W + 1)'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    // Storage array write; contents need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_buffered
// Purpose : Buffered 8N1 UART transmitter. Pushed bytes are queued, then
//           serialized LSB first on a registered RsTx line, with consecutive
//           frames sent back to back.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_FREQ   = c_DEFAULT_CLK_FREQ,
    parameter int BAUD       = c_DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  wire              clk,
    input  wire              reset,
    uart_tx_buffered_if.slave bus
);
    localparam int               c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int               c_CNT_W        = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_CLKS_PER_BIT - 1);

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shreg;
    logic               r_rs_tx;
    logic               r_sent;
    logic               r_overflow;
    logic               w_pop;
    logic               w_bit_done;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [7:0]         w_fifo_data;

    uart_tx_buffered_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (bus.tx_start),
        .i_wr_data (bus.tx_data),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_bit_done = (r_clk_cnt == c_CNT_LAST);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and pop decision; STOP chains into START when more data waits
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bit timing counter, data bit index and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else if (w_pop) begin
            r_shreg   <= w_fifo_data;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
        end else if (r_state != ST_IDLE) begin
            if (w_bit_done) begin
                r_clk_cnt <= '0;
                if (r_state == ST_DATA) begin
                    r_shreg   <= {1'b0, r_shreg[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end

    // Registered line driver and end-of-stop pulse, both one cycle behind state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rs_tx <= 1'b1;
            r_sent  <= 1'b0;
        end else begin
            case (r_state)
                ST_START: r_rs_tx <= 1'b0;
                ST_DATA:  r_rs_tx <= r_shreg[0];
                default:  r_rs_tx <= 1'b1;
            endcase
            r_sent <= (r_state == ST_STOP) && w_bit_done;
        end
    end

    // Sticky flag for pushes that arrived while the queue was full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (bus.tx_start && w_fifo_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.full     = w_fifo_full;
    assign bus.empty    = w_fifo_empty;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.sent     = r_sent;
    assign bus.overflow = r_overflow;
    assign bus.RsTx     = r_rs_tx;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_buffered
// Purpose : Directed self-checking bench for uart_tx_buffered with
//           CLK_FREQ=1000, BAUD=100 (10 clocks per bit, 100 per frame).
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx_buffered;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    uart_tx_buffered_if bus();

    uart_tx_buffered #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level at cycle k (0..99) of an 8N1 frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int bi;
        bi = k / 10;
        if (bi == 0) return 1'b0;
        if (bi >= 9) return 1'b1;
        return b[bi-1];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) step();
        checks++; if (bus.RsTx !== 1'b1)     begin failures++; $display("FAIL reset_rstx: got %b expected 1", bus.RsTx); end
        checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.sent !== 1'b0)     begin failures++; $display("FAIL reset_sent: got %b expected 0", bus.sent); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.full !== 1'b0)     begin failures++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.empty !== 1'b1)    begin failures++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if ({bus.RsTx, bus.empty, bus.busy, bus.sent} !== 4'b1100) begin
                failures++;
                $display("FAIL idle_cycle%0d: got rstx/empty/busy/sent=%b expected 1100", i,
                         {bus.RsTx, bus.empty, bus.busy, bus.sent});
            end
        end
    endtask

    task automatic test_single_frame();
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hA5;
        step();
        bus.tx_start = 1'b0;
        checks++; if (bus.RsTx !== 1'b1)  begin failures++; $display("FAIL latency_e0_rstx: got %b expected 1", bus.RsTx); end
        checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL latency_e0_empty: got %b expected 0", bus.empty); end
        step();
        checks++; if (bus.RsTx !== 1'b1)  begin failures++; $display("FAIL latency_e1_rstx: got %b expected 1", bus.RsTx); end
        checks++; if (bus.busy !== 1'b1)  begin failures++; $display("FAIL latency_e1_busy: got %b expected 1", bus.busy); end
        step();
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (bus.RsTx !== frame_bit(8'hA5, k)) begin
                failures++; $display("FAIL a5_line_k%0d: got %b expected %b", k, bus.RsTx, frame_bit(8'hA5, k));
            end
            checks++;
            if (bus.sent !== (k == 99)) begin
                failures++; $display("FAIL a5_sent_k%0d: got %b expected %b", k, bus.sent, (k == 99));
            end
            step();
        end
        checks++;
        if ({bus.RsTx, bus.busy, bus.sent} !== 3'b100) begin
            failures++; $display("FAIL a5_after: got rstx/busy/sent=%b expected 100", {bus.RsTx, bus.busy, bus.sent});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b3 [3];
        int sent_cnt;
        b3[0] = 8'h00; b3[1] = 8'hFF; b3[2] = 8'h3C;
        sent_cnt = 0;
        bus.tx_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.tx_data = b3[i];
            step();
        end
        bus.tx_start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bus.sent === 1'b1) sent_cnt++;
            checks++;
            if (bus.RsTx !== frame_bit(b3[k/100], k % 100)) begin
                failures++; $display("FAIL b2b_line_k%0d: got %b expected %b", k, bus.RsTx, frame_bit(b3[k/100], k % 100));
            end
            checks++;
            if (bus.sent !== ((k % 100) == 99)) begin
                failures++; $display("FAIL b2b_sent_k%0d: got %b expected %b", k, bus.sent, ((k % 100) == 99));
            end
            checks++;
            if (bus.busy !== (k < 299)) begin
                failures++; $display("FAIL b2b_busy_k%0d: got %b expected %b", k, bus.busy, (k < 299));
            end
            checks++;
            if (bus.empty !== (k >= 199)) begin
                failures++; $display("FAIL b2b_empty_k%0d: got %b expected %b", k, bus.empty, (k >= 199));
            end
            step();
        end
        checks++;
        if (sent_cnt !== 3) begin failures++; $display("FAIL b2b_sent_count: got %0d expected 3", sent_cnt); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [$];
        logic [7:0] rx_q [$];
        logic [7:0] rx_byte;
        bit         rx_active;
        int         rx_cnt;
        int         sent_cnt;
        rx_active = 1'b0; rx_cnt = 0; rx_byte = 8'h00; sent_cnt = 0;
        exp_q.push_back(8'hC3);
        for (int j = 0; j < 16; j++) exp_q.push_back(8'(8'h30 + j));
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre: got %b expected 0", bus.overflow); end
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hC3;
        step();
        for (int c = 0; c < 1900; c++) begin
            if (!rx_active) begin
                if (bus.RsTx === 1'b0) begin rx_active = 1'b1; rx_cnt = 0; end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 15 && rx_cnt <= 85 && ((rx_cnt - 5) % 10) == 0) rx_byte[(rx_cnt - 15) / 10] = bus.RsTx;
                if (rx_cnt == 95) begin rx_q.push_back(rx_byte); rx_active = 1'b0; end
            end
            if (bus.sent === 1'b1) sent_cnt++;
            if (c == 60) begin
                checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL ovf_full_15: got %b expected 0", bus.full); end
            end
            if (c == 61) begin
                checks++; if (bus.full !== 1'b1)     begin failures++; $display("FAIL ovf_full_16: got %b expected 1", bus.full); end
                checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag_16: got %b expected 0", bus.overflow); end
            end
            if (c == 62) begin
                checks++; if (bus.full !== 1'b1)     begin failures++; $display("FAIL ovf_full_17: got %b expected 1", bus.full); end
                checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag_17: got %b expected 1", bus.overflow); end
            end
            if (c >= 45 && c <= 61) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'(8'h30 + (c - 45));
            end else begin
                bus.tx_start = 1'b0;
            end
            step();
        end
        checks++; if (rx_q.size() !== 17) begin failures++; $display("FAIL ovf_frames: got %0d expected 17", rx_q.size()); end
        for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (sent_cnt !== 17)       begin failures++; $display("FAIL ovf_sent_count: got %0d expected 17", sent_cnt); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
        checks++; if (bus.empty !== 1'b1)    begin failures++; $display("FAIL ovf_empty_end: got %b expected 1", bus.empty); end
        checks++; if (bus.full !== 1'b0)     begin failures++; $display("FAIL ovf_full_end: got %b expected 0", bus.full); end
        checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL ovf_busy_end: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_frame();
        bus.tx_start = 1'b1;
        bus.tx_data = 8'h11; step();
        bus.tx_data = 8'h22; step();
        bus.tx_data = 8'h33; step();
        bus.tx_start = 1'b0;
        repeat (45) step();
        checks++; if (bus.RsTx !== 1'b0) begin failures++; $display("FAIL rst_mid_pre_rstx: got %b expected 0", bus.RsTx); end
        reset = 1'b1;
        #1;
        checks++; if (bus.RsTx !== 1'b1)     begin failures++; $display("FAIL rst_mid_rstx: got %b expected 1", bus.RsTx); end
        checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.empty !== 1'b1)    begin failures++; $display("FAIL rst_mid_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_overflow: got %b expected 0", bus.overflow); end
        repeat (2) step();
        reset = 1'b0;
        step();
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h96;
        step();
        bus.tx_start = 1'b0;
        step();
        checks++; if (bus.RsTx !== 1'b1) begin failures++; $display("FAIL post_rst_latency: got %b expected 1", bus.RsTx); end
        step();
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (bus.RsTx !== frame_bit(8'h96, k)) begin
                failures++; $display("FAIL post_rst_line_k%0d: got %b expected %b", k, bus.RsTx, frame_bit(8'h96, k));
            end
            checks++;
            if (bus.sent !== (k == 99)) begin
                failures++; $display("FAIL post_rst_sent_k%0d: got %b expected %b", k, bus.sent, (k == 99));
            end
            step();
        end
    endtask

    task automatic test_full_pop_same_cycle();
        checks++; if (bus.empty !== 1'b1)    begin failures++; $display("FAIL fp_pre_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fp_pre_overflow: got %b expected 0", bus.overflow); end
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h5A;
        step();
        for (int i = 0; i < 16; i++) begin
            bus.tx_data = 8'(8'h80 + i);
            step();
        end
        bus.tx_start = 1'b0;
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fp_filled: got %b expected 1", bus.full); end
        repeat (84) step();
        checks++; if (bus.full !== 1'b1)     begin failures++; $display("FAIL fp_full_before: got %b expected 1", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fp_ovf_before: got %b expected 0", bus.overflow); end
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h55;
        step();
        checks++; if (bus.full !== 1'b0)     begin failures++; $display("FAIL fp_full_after_pop: got %b expected 0", bus.full); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fp_ovf_after: got %b expected 1", bus.overflow); end
        bus.tx_data = 8'h77;
        step();
        bus.tx_start = 1'b0;
        checks++; if (bus.full !== 1'b1)     begin failures++; $display("FAIL fp_refill: got %b expected 1", bus.full); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fp_ovf_sticky: got %b expected 1", bus.overflow); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_full_pop_same_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
